// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: PC handshake, program-memory read port and decoder handshake.
interface instr_fetch_if #(
    parameter int ADDR_W  = 5,
    parameter int INSTR_W = 8
);
    logic [ADDR_W-1:0]  pc_val;
    logic               pc_max;
    logic               pc_inc;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_rd;
    logic [INSTR_W-1:0] mem_rdata;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               instr_ready;

    modport master (
        input  pc_val, pc_max, mem_rdata, instr_ready,
        output pc_inc, mem_addr, mem_rd, instr, instr_valid
    );

    modport slave (
        output pc_val, pc_max, mem_rdata, instr_ready,
        input  pc_inc, mem_addr, mem_rd, instr, instr_valid
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC -> synchronous program memory -> held word for the decoder.
// Optional accepted-instruction counter enabled by macro IFETCH_STATS_EN.
module instr_fetch #(
    parameter int ADDR_W  = 5,
    parameter int INSTR_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    instr_fetch_if.master       bus,
    output logic                halt,
    output logic [7:0]          fetch_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_HALT
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               rd_issue;
    logic               accept;

    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        instr_d    = instr_q;
        rd_issue   = 1'b0;
        accept     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.pc_max)   state_d = S_HALT;
                else if (run)     state_d = S_REQ;
            end
            S_REQ: begin
                // A wrapped PC must never reach memory: address 0 is not re-read.
                if (bus.pc_max) begin
                    state_d = S_HALT;
                end else begin
                    rd_issue   = 1'b1;
                    mem_addr_d = bus.pc_val;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                instr_d = bus.mem_rdata;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (bus.instr_ready) begin
                    accept  = 1'b1;
                    state_d = run ? S_REQ : S_IDLE;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
        // Reset discards the held word, so its accept must not bump the PC.
        if (rst) accept = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            mem_addr_q <= '0;
            instr_q    <= '0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            instr_q    <= instr_d;
        end
    end

    assign bus.mem_rd      = rd_issue;
    assign bus.mem_addr    = rd_issue ? bus.pc_val : mem_addr_q;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = (state_q == S_HOLD);
    assign bus.pc_inc      = accept;
    // Flag the halt already in the REQ cycle that sees the wrapped PC.
    assign halt            = (state_q == S_HALT) || ((state_q == S_REQ) && bus.pc_max);

`ifdef IFETCH_STATS_EN
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (accept && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign fetch_cnt = cnt_q;
`else
    assign fetch_cnt = '0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: cycle table, hand sequences and a randomized scoreboard.
module tb_instr_fetch;
    localparam int AW = 5;
    localparam int IW = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic       rdy = 1'b0;
    logic       halt;
    logic [7:0] fetch_cnt;

    always #5 clk = ~clk;

    instr_fetch_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

    instr_fetch #(.ADDR_W(AW), .INSTR_W(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .bus       (bus),
        .halt      (halt),
        .fetch_cnt (fetch_cnt)
    );

    // Synchronous program memory
    logic [IW-1:0] mem [32];
    logic [IW-1:0] rdata_r;
    always @(posedge clk) if (bus.mem_rd) rdata_r <= mem[bus.mem_addr];
    assign bus.mem_rdata   = rdata_r;
    assign bus.instr_ready = rdy;

    // Program counter with sticky wrap flag
    logic [AW-1:0] pc, pc_init;
    logic          pc_max_r;
    bit            no_wrap = 1'b0;
    always @(posedge clk) begin
        if (rst) begin
            pc       <= pc_init;
            pc_max_r <= 1'b0;
        end else if (bus.pc_inc) begin
            pc <= pc + 5'd1;
            if (pc == 5'd31 && !no_wrap) pc_max_r <= 1'b1;
        end
    end
    assign bus.pc_val = pc;
    assign bus.pc_max = pc_max_r;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Scoreboard: reads and accepts walk addresses in order from the start PC
    logic [AW-1:0] exp_rd, exp_acc;
    int            accepts, rd0;
    logic [IW-1:0] prev_instr;
    bit            prev_hold;

    task automatic observe();
        if (bus.mem_rd) begin
            chk("rd_addr", bus.mem_addr, exp_rd);
            if (bus.mem_addr == 5'd0) rd0++;
            exp_rd = exp_rd + 5'd1;
        end
        if (prev_hold) chk("hold_stable", {bus.instr_valid, bus.instr}, {1'b1, prev_instr});
        if (bus.pc_inc) begin
            chk("acc_data", {bus.instr_valid, bus.instr}, {1'b1, mem[exp_acc]});
            exp_acc = exp_acc + 5'd1;
            accepts++;
        end
        prev_hold  = bus.instr_valid && !rdy;
        prev_instr = bus.instr;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; run = 1'b0; rdy = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_outs", {bus.pc_inc, bus.mem_rd, bus.instr_valid, halt,
                         bus.mem_addr, bus.instr, fetch_cnt}, 32'd0);
        rst = 1'b0;
        exp_rd = pc_init; exp_acc = pc_init;
        accepts = 0; rd0 = 0; prev_hold = 1'b0;
    endtask

    typedef struct packed {
        logic       run;
        logic       rdy;
        logic       rd;
        logic [4:0] addr;
        logic       v;
        logic [7:0] ins;
        logic       inc;
    } vec_t;

    vec_t tbl [13];
    int   acc32;
    bit   halted;

    initial begin
        // run rdy | mem_rd addr valid instr pc_inc
        tbl[0]  = {1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 8'h00, 1'b0};
        tbl[1]  = {1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 8'h00, 1'b0};
        tbl[2]  = {1'b1, 1'b1, 1'b0, 5'd3, 1'b0, 8'h00, 1'b0};
        tbl[3]  = {1'b1, 1'b1, 1'b0, 5'd3, 1'b1, 8'hA5, 1'b1};
        tbl[4]  = {1'b1, 1'b0, 1'b1, 5'd4, 1'b0, 8'hA5, 1'b0};
        tbl[5]  = {1'b1, 1'b0, 1'b0, 5'd4, 1'b0, 8'hA5, 1'b0};
        tbl[6]  = {1'b1, 1'b0, 1'b0, 5'd4, 1'b1, 8'h3C, 1'b0};
        tbl[7]  = {1'b1, 1'b0, 1'b0, 5'd4, 1'b1, 8'h3C, 1'b0};
        tbl[8]  = {1'b1, 1'b0, 1'b0, 5'd4, 1'b1, 8'h3C, 1'b0};
        tbl[9]  = {1'b1, 1'b0, 1'b0, 5'd4, 1'b1, 8'h3C, 1'b0};
        tbl[10] = {1'b0, 1'b1, 1'b0, 5'd4, 1'b1, 8'h3C, 1'b1};
        tbl[11] = {1'b0, 1'b1, 1'b0, 5'd4, 1'b0, 8'h3C, 1'b0};
        tbl[12] = {1'b0, 1'b0, 1'b0, 5'd4, 1'b0, 8'h3C, 1'b0};

        for (int a = 0; a < 32; a++) mem[a] = 8'($urandom);

        // Basic fetch followed by a 4-cycle backpressure hold
        mem[3] = 8'hA5; mem[4] = 8'h3C; pc_init = 5'd3;
        do_reset();
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            run = tbl[i].run; rdy = tbl[i].rdy;
            #1;
            chk($sformatf("vec%0d", i),
                {bus.mem_rd, bus.mem_addr, bus.instr_valid, bus.instr, bus.pc_inc},
                {tbl[i].rd, tbl[i].addr, tbl[i].v, tbl[i].ins, tbl[i].inc});
        end

        // Stop request during WAIT, then resume at the incremented PC
        mem[7] = 8'h5A; pc_init = 5'd7;
        do_reset();
        @(negedge clk); run = 1'b1; rdy = 1'b0;
        @(negedge clk); #1 chk("stop_req", {bus.mem_rd, bus.mem_addr}, {1'b1, 5'd7});
        @(negedge clk); run = 1'b0; #1 chk("stop_wait_rd", bus.mem_rd, 1'b0);
        @(negedge clk); rdy = 1'b1;
        #1 chk("stop_acc", {bus.instr_valid, bus.instr, bus.pc_inc}, {1'b1, 8'h5A, 1'b1});
        @(negedge clk); rdy = 1'b0; #1 chk("stop_idle", {bus.mem_rd, bus.instr_valid}, 2'b00);
        @(negedge clk); #1 chk("stop_idle2", bus.mem_rd, 1'b0);
        run = 1'b1;
        @(negedge clk); #1 chk("resume_addr", {bus.mem_rd, bus.mem_addr}, {1'b1, 5'd8});

        // Reset while a word is held
        @(negedge clk);
        @(negedge clk); #1 chk("pre_rst_valid", bus.instr_valid, 1'b1);
        @(negedge clk); rst = 1'b1; rdy = 1'b1;
        #1 chk("rst_no_inc", bus.pc_inc, 1'b0);
        @(negedge clk); #1
        chk("rst_mid_outs", {bus.pc_inc, bus.mem_rd, bus.instr_valid, halt,
                             bus.mem_addr, bus.instr, fetch_cnt}, 32'd0);
        rst = 1'b0; run = 1'b0; rdy = 1'b0;

        // Full run-through to wrap with random decoder backpressure
        no_wrap = 1'b0; pc_init = 5'd0;
        do_reset();
        run = 1'b1; acc32 = -1; halted = 1'b0;
        for (int c = 0; c < 1000 && !halted; c++) begin
            @(negedge clk);
            rdy = 1'($urandom_range(0, 1));
            #1;
            observe();
            if (bus.pc_inc && accepts == 32) acc32 = c;
            if (halt) begin
                halted = 1'b1;
                chk("halt_lat", c - acc32, 1);
            end
        end
        if (!halted) chk("halt_seen", 0, 1);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            run = 1'($urandom_range(0, 1)); rdy = 1'($urandom_range(0, 1));
            #1 chk("halt_sticky", {halt, bus.instr_valid, bus.mem_rd, bus.pc_inc}, 4'b1000);
        end
        chk("wrap_accepts", accepts, 32);
        chk("wrap_rd0", rd0, 1);
`ifdef IFETCH_STATS_EN
        chk("cnt_wrap", fetch_cnt, 32);
`else
        chk("cnt_off", fetch_cnt, 0);
`endif

        // Randomized run/ready without wrap
        no_wrap = 1'b1; pc_init = 5'($urandom);
        do_reset();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            run = ($urandom_range(0, 3) != 0); rdy = 1'($urandom_range(0, 1));
            #1 observe();
        end
        chk("rand_progress", accepts > 10, 1);
`ifdef IFETCH_STATS_EN
        chk("rand_cnt", fetch_cnt, (accepts > 255) ? 255 : accepts);

        // Counter saturation
        pc_init = 5'd0;
        do_reset();
        run = 1'b1; rdy = 1'b1;
        for (int c = 0; c < 1500 && accepts < 300; c++) begin
            @(negedge clk); #1 observe();
        end
        chk("sat_accepts", accepts, 300);
        @(negedge clk); #1 chk("cnt_sat", fetch_cnt, 255);
`else
        chk("rand_cnt_off", fetch_cnt, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
